// File: rtl/csd_pkg.sv
// -----------------------------------------------------------------------------
// csd_pkg
// Shared definitions for the Clifford systolic dataflow feeder and its array
// bench monitors: geometry constants, the coefficient word type and the
// feeder state encoding.
// -----------------------------------------------------------------------------
package csd_pkg;

  // Coefficients per multivector, which is also the number of array rows.
  localparam int GA_DIM = 32;
  // Coefficient width; the FP32 bit pattern is carried and never interpreted.
  localparam int WORD_W = 32;
  // Width of a basis-blade index.
  localparam int IDX_W  = $clog2(GA_DIM);

  typedef logic [WORD_W-1:0] csd_word_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    WLOAD    = 3'd2,
    WAIT_ARR = 3'd3,
    FEED     = 3'd4,
    DRAIN    = 3'd5
  } csd_feed_state_t;

  // States in which the feeder accepts input beats.
  function automatic logic accepts_input(input csd_feed_state_t st);
    return (st == IDLE) || (st == COLLECT) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/csd_feed_buf.sv
// -----------------------------------------------------------------------------
// csd_feed_buf
// GA_DIM x WORD_W register file holding one multivector. One write port and a
// full parallel read so every lane mux sees its coefficient directly.
//
// Ports:
//   clk     in   clock, rising edge
//   we      in   write enable
//   widx    in   basis index to write
//   wdata   in   coefficient to write
//   rd_all  out  all entries; entry k occupies bits [k*WORD_W +: WORD_W]
// -----------------------------------------------------------------------------
module csd_feed_buf
  import csd_pkg::*;
(
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [GA_DIM*WORD_W-1:0] rd_all
);

  // Entries are not reset: every entry is rewritten by a complete packet
  // before it is ever read out.
  csd_word_t mem_r [GA_DIM];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[widx] <= wdata;
    end else begin
      mem_r[widx] <= mem_r[widx];
    end
  end

  // Flatten the storage onto the parallel read bus.
  always_comb begin
    rd_all = {(GA_DIM*WORD_W){1'b0}};
    for (int k = 0; k < GA_DIM; k++) begin
      rd_all[k*WORD_W +: WORD_W] = mem_r[k];
    end
  end

endmodule

// File: rtl/csd_feeder.sv
// -----------------------------------------------------------------------------
// csd_feeder
// Upstream feed stage for the Clifford systolic dataflow array. Collects one
// multivector (GA_DIM FP32 beats) from a valid/ready stream, then replays it
// either as a weight-load sequence (V) or as a row-skewed query wavefront with
// a run_compute pulse (Q), waiting for the array to be idle first.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid/in_ready/in_data/in_last/in_is_v   input beat stream
//   array_busy    array is still computing (delays a Q feed)
//   load_weights, v_in_data, v_idx              weight-load port
//   run_compute, q_skew, q_lane_valid           skewed query port
//   busy          feeder not IDLE
//   err_len       one-cycle pulse on a malformed multivector
// All outputs are registered.
// -----------------------------------------------------------------------------
module csd_feeder
  import csd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_data,
  input  logic                     in_last,
  input  logic                     in_is_v,
  input  logic                     array_busy,
  output logic                     load_weights,
  output logic [WORD_W-1:0]        v_in_data,
  output logic [IDX_W-1:0]         v_idx,
  output logic                     run_compute,
  output logic [GA_DIM*WORD_W-1:0] q_skew,
  output logic [GA_DIM-1:0]        q_lane_valid,
  output logic                     busy,
  output logic                     err_len
);

  localparam logic [IDX_W-1:0] BEAT_LAST  = IDX_W'(GA_DIM - 1);
  localparam logic [IDX_W:0]   WLOAD_LAST = (IDX_W+1)'(GA_DIM - 1);
  localparam logic [IDX_W:0]   FEED_LAST  = (IDX_W+1)'(2*GA_DIM - 2);
  localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] BEAT_ONE   = IDX_W'(1);

  // FSM state and counters
  csd_feed_state_t    state_r, state_nxt_s;
  logic [IDX_W-1:0]   beat_cnt_r, beat_cnt_nxt_s;
  logic [IDX_W:0]     cnt_r, cnt_nxt_s;
  logic               kind_r, kind_nxt_s;

  logic               accept_s;
  logic               err_s;
  logic               buf_we_s;
  logic [IDX_W-1:0]   buf_widx_s;
  logic [GA_DIM*WORD_W-1:0] buf_rd_s;

  // Next-cycle output values, captured into the output registers
  logic                     in_ready_s, in_ready_r;
  logic                     load_s, load_r;
  csd_word_t                v_data_s, v_data_r;
  logic [IDX_W-1:0]         v_idx_s, v_idx_r;
  logic                     run_s, run_r;
  logic [GA_DIM*WORD_W-1:0] skew_s, skew_r;
  logic [GA_DIM-1:0]        lane_valid_s, lane_valid_r;
  logic                     busy_s, busy_r;
  logic                     err_r;

  // The handshake uses the registered ready that the source actually sees.
  assign accept_s = in_valid & in_ready_r;

  csd_feed_buf u_buf (
    .clk    (clk),
    .we     (buf_we_s),
    .widx   (buf_widx_s),
    .wdata  (in_data),
    .rd_all (buf_rd_s)
  );

  // Next-state, counter and buffer-write decode.
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    cnt_nxt_s      = cnt_r;
    kind_nxt_s     = kind_r;
    err_s          = 1'b0;
    buf_we_s       = 1'b0;
    buf_widx_s     = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          buf_we_s   = 1'b1;
          buf_widx_s = {IDX_W{1'b0}};
          kind_nxt_s = in_is_v;
          if (in_last) begin
            // A one-beat multivector is malformed; stay ready for the next.
            err_s          = 1'b1;
            beat_cnt_nxt_s = {IDX_W{1'b0}};
          end else begin
            state_nxt_s    = COLLECT;
            beat_cnt_nxt_s = BEAT_ONE;
          end
        end else begin
          beat_cnt_nxt_s = {IDX_W{1'b0}};
        end
      end
      COLLECT: begin
        if (accept_s) begin
          buf_we_s = 1'b1;
          if (beat_cnt_r == BEAT_LAST) begin
            beat_cnt_nxt_s = {IDX_W{1'b0}};
            cnt_nxt_s      = {(IDX_W+1){1'b0}};
            if (in_last) begin
              if (kind_r) begin
                state_nxt_s = WLOAD;
              end else if (array_busy) begin
                state_nxt_s = WAIT_ARR;
              end else begin
                // Array already idle: enter FEED directly so the pulse
                // lands in the cycle right after the last beat.
                state_nxt_s = FEED;
              end
            end else begin
              err_s       = 1'b1;
              state_nxt_s = DRAIN;
            end
          end else if (in_last) begin
            err_s          = 1'b1;
            state_nxt_s    = IDLE;
            beat_cnt_nxt_s = {IDX_W{1'b0}};
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + BEAT_ONE;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      DRAIN: begin
        if (accept_s && in_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      WLOAD: begin
        if (cnt_r == WLOAD_LAST) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {(IDX_W+1){1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_ARR: begin
        if (!array_busy) begin
          state_nxt_s = FEED;
          cnt_nxt_s   = {(IDX_W+1){1'b0}};
        end else begin
          state_nxt_s = WAIT_ARR;
        end
      end
      FEED: begin
        if (cnt_r == FEED_LAST) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {(IDX_W+1){1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        beat_cnt_nxt_s = {IDX_W{1'b0}};
        cnt_nxt_s      = {(IDX_W+1){1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    in_ready_s   = accepts_input(state_nxt_s);
    busy_s       = (state_nxt_s != IDLE);
    load_s       = 1'b0;
    v_idx_s      = {IDX_W{1'b0}};
    v_data_s     = {WORD_W{1'b0}};
    run_s        = 1'b0;
    lane_valid_s = {GA_DIM{1'b0}};
    skew_s       = {(GA_DIM*WORD_W){1'b0}};
    if (state_nxt_s == WLOAD) begin
      load_s   = 1'b1;
      v_idx_s  = cnt_nxt_s[IDX_W-1:0];
      v_data_s = buf_rd_s[v_idx_s*WORD_W +: WORD_W];
    end else begin
      load_s = 1'b0;
    end
    if (state_nxt_s == FEED) begin
      run_s = (cnt_nxt_s == {(IDX_W+1){1'b0}});
      // Lane r carries its coefficient only on feed cycle r; the tail
      // cycles (f >= GA_DIM) match no lane and leave everything zero.
      for (int r = 0; r < GA_DIM; r++) begin
        if (cnt_nxt_s == (IDX_W+1)'(r)) begin
          lane_valid_s[r]              = 1'b1;
          skew_s[r*WORD_W +: WORD_W] = buf_rd_s[r*WORD_W +: WORD_W];
        end else begin
          lane_valid_s[r] = 1'b0;
        end
      end
    end else begin
      run_s = 1'b0;
    end
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      beat_cnt_r   <= {IDX_W{1'b0}};
      cnt_r        <= {(IDX_W+1){1'b0}};
      kind_r       <= 1'b0;
      in_ready_r   <= 1'b0;
      load_r       <= 1'b0;
      v_data_r     <= {WORD_W{1'b0}};
      v_idx_r      <= {IDX_W{1'b0}};
      run_r        <= 1'b0;
      skew_r       <= {(GA_DIM*WORD_W){1'b0}};
      lane_valid_r <= {GA_DIM{1'b0}};
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      beat_cnt_r   <= beat_cnt_nxt_s;
      cnt_r        <= cnt_nxt_s;
      kind_r       <= kind_nxt_s;
      in_ready_r   <= in_ready_s;
      load_r       <= load_s;
      v_data_r     <= v_data_s;
      v_idx_r      <= v_idx_s;
      run_r        <= run_s;
      skew_r       <= skew_s;
      lane_valid_r <= lane_valid_s;
      busy_r       <= busy_s;
      err_r        <= err_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign load_weights = load_r;
  assign v_in_data    = v_data_r;
  assign v_idx        = v_idx_r;
  assign run_compute  = run_r;
  assign q_skew       = skew_r;
  assign q_lane_valid = lane_valid_r;
  assign busy         = busy_r;
  assign err_len      = err_r;

endmodule

// File: tb/tb_csd_feeder.sv
// -----------------------------------------------------------------------------
// tb_csd_feeder
// Directed self-checking bench for csd_feeder (GA_DIM = 32, WORD_W = 32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_csd_feeder;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_is_v;
  logic          array_busy;
  logic          load_weights;
  logic [31:0]   v_in_data;
  logic [4:0]    v_idx;
  logic          run_compute;
  logic [1023:0] q_skew;
  logic [31:0]   q_lane_valid;
  logic          busy;
  logic          err_len;

  int n_cmp = 0;
  int n_err = 0;

  csd_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_is_v      (in_is_v),
    .array_busy   (array_busy),
    .load_weights (load_weights),
    .v_in_data    (v_in_data),
    .v_idx        (v_idx),
    .run_compute  (run_compute),
    .q_skew       (q_skew),
    .q_lane_valid (q_lane_valid),
    .busy         (busy),
    .err_len      (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n beats base+k; in_is_v carries 'is_v' on beat 0 and its inverse
  // afterwards, since only beat 0 may be sampled. Returns in the cycle after
  // the last accepting edge.
  task automatic send_pkt(input int n, input logic [31:0] base, input logic is_v, input int last_at);
    for (int k = 0; k < n; k++) begin
      int guard;
      in_valid = 1'b1;
      in_data  = base + k;
      in_last  = (k == last_at);
      in_is_v  = (k == 0) ? is_v : ~is_v;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 100) begin
        step();
        guard++;
      end
      check_eq($sformatf("rdy_wait_%0d", k), {63'd0, in_ready}, 64'd1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_is_v  = 1'b0;
  endtask

  // Expects the 32-cycle weight load starting in the current cycle.
  task automatic check_load(input string tag, input logic [31:0] base);
    for (int i = 0; i < 32; i++) begin
      check_eq($sformatf("%s_lw_%0d", tag, i), {63'd0, load_weights}, 64'd1);
      check_eq($sformatf("%s_idx_%0d", tag, i), {59'd0, v_idx}, 64'(i));
      check_eq($sformatf("%s_dat_%0d", tag, i), {32'd0, v_in_data}, {32'd0, base + 32'(i)});
      check_eq($sformatf("%s_run_%0d", tag, i), {63'd0, run_compute}, 64'd0);
      step();
    end
    check_eq({tag, "_lw_end"}, {63'd0, load_weights}, 64'd0);
    check_eq({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_rdy_end"}, {63'd0, in_ready}, 64'd1);
  endtask

  // Expects the 63-cycle skewed query wavefront starting in the current cycle.
  task automatic check_feed(input string tag, input logic [31:0] base);
    for (int f = 0; f < 63; f++) begin
      logic [31:0]   exp_v;
      logic [1023:0] exp_q;
      exp_v = (f < 32) ? (32'd1 << f) : 32'd0;
      exp_q = {1024{1'b0}};
      if (f < 32) exp_q[f*32 +: 32] = base + 32'(f);
      check_eq($sformatf("%s_run_%0d", tag, f), {63'd0, run_compute}, (f == 0) ? 64'd1 : 64'd0);
      check_eq($sformatf("%s_lv_%0d", tag, f), {32'd0, q_lane_valid}, {32'd0, exp_v});
      check_eq($sformatf("%s_skew_%0d", tag, f), {63'd0, (q_skew === exp_q)}, 64'd1);
      check_eq($sformatf("%s_busy_%0d", tag, f), {63'd0, busy}, 64'd1);
      step();
    end
    check_eq({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_rdy_end"}, {63'd0, in_ready}, 64'd1);
    check_eq({tag, "_lv_end"}, {32'd0, q_lane_valid}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 32'd0;
    in_last    = 1'b0;
    in_is_v    = 1'b0;
    array_busy = 1'b0;

    // Reset state
    step();
    step();
    check_eq("rst_rdy", {63'd0, in_ready}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_lw", {63'd0, load_weights}, 64'd0);
    check_eq("rst_run", {63'd0, run_compute}, 64'd0);
    check_eq("rst_lv", {32'd0, q_lane_valid}, 64'd0);
    check_eq("rst_err", {63'd0, err_len}, 64'd0);
    rst = 1'b0;
    step();
    check_eq("rel_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("rel_busy", {63'd0, busy}, 64'd0);

    // V packet
    send_pkt(32, 32'h3F80_0000, 1'b1, 31);
    check_load("v1", 32'h3F80_0000);

    // Q packet, array idle
    send_pkt(32, 32'h0000_0000, 1'b0, 31);
    check_feed("q1", 32'h0000_0000);

    // Q packet, array busy at the last beat and for 9 more edges
    array_busy = 1'b1;
    send_pkt(32, 32'h0000_0200, 1'b0, 31);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("stall_run_%0d", i), {63'd0, run_compute}, 64'd0);
      check_eq($sformatf("stall_lv_%0d", i), {32'd0, q_lane_valid}, 64'd0);
      check_eq($sformatf("stall_busy_%0d", i), {63'd0, busy}, 64'd1);
      check_eq($sformatf("stall_rdy_%0d", i), {63'd0, in_ready}, 64'd0);
      if (i == 9) array_busy = 1'b0;
      step();
    end
    check_feed("q2", 32'h0000_0200);

    // Early in_last on beat 5, then a well-formed V packet
    send_pkt(6, 32'h1111_0000, 1'b1, 5);
    check_eq("early_err", {63'd0, err_len}, 64'd1);
    check_eq("early_lw", {63'd0, load_weights}, 64'd0);
    check_eq("early_busy", {63'd0, busy}, 64'd0);
    check_eq("early_rdy", {63'd0, in_ready}, 64'd1);
    step();
    check_eq("early_err_off", {63'd0, err_len}, 64'd0);
    check_eq("early_lw2", {63'd0, load_weights}, 64'd0);
    check_eq("early_run2", {63'd0, run_compute}, 64'd0);
    send_pkt(32, 32'hA500_0000, 1'b1, 31);
    check_load("v2", 32'hA500_0000);

    // 40 beats with in_last on beat 39
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_0000 + 32'(k);
      in_last  = (k == 39);
      in_is_v  = 1'b1;
      check_eq($sformatf("long_rdy_%0d", k), {63'd0, in_ready}, 64'd1);
      step();
      check_eq($sformatf("long_err_%0d", k), {63'd0, err_len}, (k == 31) ? 64'd1 : 64'd0);
      check_eq($sformatf("long_lw_%0d", k), {63'd0, load_weights}, 64'd0);
      check_eq($sformatf("long_busy_%0d", k), {63'd0, busy}, (k == 39) ? 64'd0 : 64'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_is_v  = 1'b0;
    step();
    check_eq("long_lw_after", {63'd0, load_weights}, 64'd0);
    check_eq("long_run_after", {63'd0, run_compute}, 64'd0);
    check_eq("long_err_after", {63'd0, err_len}, 64'd0);

    // Reset at feed cycle 12
    send_pkt(32, 32'h0000_0100, 1'b0, 31);
    for (int f = 0; f <= 12; f++) begin
      check_eq($sformatf("rf_lv_%0d", f), {32'd0, q_lane_valid}, {32'd0, 32'd1 << f});
      if (f < 12) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("ra_rdy", {63'd0, in_ready}, 64'd0);
    check_eq("ra_busy", {63'd0, busy}, 64'd0);
    check_eq("ra_lv", {32'd0, q_lane_valid}, 64'd0);
    check_eq("ra_skew", {63'd0, (q_skew === {1024{1'b0}})}, 64'd1);
    check_eq("ra_run", {63'd0, run_compute}, 64'd0);
    check_eq("ra_lw", {63'd0, load_weights}, 64'd0);
    step();
    check_eq("rb_rdy", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rc_lv_%0d", i), {32'd0, q_lane_valid}, 64'd0);
      check_eq($sformatf("rc_busy_%0d", i), {63'd0, busy}, 64'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
